// File: rtl/rs232in_fifo_pkg.sv
// Shared definitions for the rs232 peripheral: register offsets and receive-queue defaults.
package rs232in_fifo_pkg;

    typedef enum logic [1:0] {
        RS232OUT_DATA = 2'd0,
        RS232IN_DATA  = 2'd1,
        RS232IN_COUNT = 2'd2,
        TSC           = 2'd3
    } rs232_reg_e;

    localparam int RS232IN_DEPTH_LOG2 = 4;
    localparam int RS232IN_HI_WATER   = 12;
    localparam int RS232IN_LO_WATER   = 4;

    function automatic int unsigned depth_of(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

endpackage

// File: rtl/rs232in_fifo_if.sv
// Receive-side bundle between rs232in, the receive queue and the peripheral register file.
interface rs232in_fifo_if
    import rs232in_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232IN_DEPTH_LOG2
);
    logic                  rx_attention;
    logic [7:0]            rx_data;
    logic                  rd;
    logic [7:0]            rd_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overrun;
    logic                  clr_overrun;
    logic                  ser_nrts;

    modport master (
        output rx_attention, rx_data, rd, clr_overrun,
        input  rd_data, count, empty, full, overrun, ser_nrts
    );

    modport slave (
        input  rx_attention, rx_data, rd, clr_overrun,
        output rd_data, count, empty, full, overrun, ser_nrts
    );
endinterface

// File: rtl/rs232in_fifo_mem.sv
// Byte storage for the receive queue: synchronous write, asynchronous read (distributed/LE RAM).
module fifo_mem
    import rs232in_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232IN_DEPTH_LOG2,
    parameter int WIDTH      = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [depth_of(DEPTH_LOG2)];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/rs232in_fifo.sv
// Receive queue for rs232in: first-word-fall-through FIFO, sticky overrun and RTS hysteresis.
module rs232in_fifo
    import rs232in_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232IN_DEPTH_LOG2,
    parameter int HI_WATER   = RS232IN_HI_WATER,
    parameter int LO_WATER   = RS232IN_LO_WATER
) (
    input  logic          clock,
    input  logic          rst,
    rs232in_fifo_if.slave bus
);
    localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(depth_of(DEPTH_LOG2));
    localparam logic [DEPTH_LOG2:0] HI    = (DEPTH_LOG2+1)'(HI_WATER);
    localparam logic [DEPTH_LOG2:0] LO    = (DEPTH_LOG2+1)'(LO_WATER);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  empty;
    logic                  full;
    logic                  overrun;
    logic                  ser_nrts;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // A push into a full queue is still accepted when the same cycle vacates the head slot.
    assign push = bus.rx_attention & (~full | bus.rd);
    assign pop  = bus.rd & ~empty;
    assign drop = bus.rx_attention & full & ~bus.rd;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overrun  <= 1'b0;
            ser_nrts <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            empty   <= (count_next == '0);
            full    <= (count_next == DEPTH);
            overrun <= drop | (overrun & ~bus.clr_overrun);
            // Hysteresis on the current count; between the marks the line holds.
            if (count >= HI) begin
                ser_nrts <= 1'b1;
            end else if (count <= LO) begin
                ser_nrts <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_mem (
        .clock   (clock),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.rx_data),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );

    assign bus.count    = count;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.overrun  = overrun;
    assign bus.ser_nrts = ser_nrts;
endmodule

// File: tb/tb_rs232in_fifo.sv
// Self-checking bench for rs232in_fifo: vector table plus scoreboard-driven corner sequences.
module tb_rs232in_fifo;

    logic clock;
    logic rst;

    rs232in_fifo_if #(.DEPTH_LOG2(4)) bus ();

    rs232in_fifo #(
        .DEPTH_LOG2 (4),
        .HI_WATER   (12),
        .LO_WATER   (4)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] q [$];
    logic       m_ov;
    logic       m_nrts;
    logic [7:0] last_pop;

    typedef struct {
        logic       att;
        logic [7:0] data;
        logic       rd;
        int         exp_count;
        logic       exp_empty;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic att, input logic [7:0] d, input logic r, input logic c);
        int  c0;
        logic full_m, do_push, do_pop;
        bus.rx_attention = att;
        bus.rx_data      = d;
        bus.rd           = r;
        bus.clr_overrun  = c;
        c0      = q.size();
        full_m  = (c0 == 16);
        do_push = att && (!full_m || r);
        do_pop  = r && (c0 > 0);
        if (do_pop) begin
            chk("pop_data", int'(bus.rd_data), int'(q[0]));
            last_pop = bus.rd_data;
            void'(q.pop_front());
        end
        if (do_push) q.push_back(d);
        if (att && full_m && !r) m_ov = 1'b1;
        else if (c) m_ov = 1'b0;
        if (c0 >= 12) m_nrts = 1'b1;
        else if (c0 <= 4) m_nrts = 1'b0;
        @(posedge clock);
        #1;
        chk("count", int'(bus.count), q.size());
        chk("empty", int'(bus.empty), int'(q.size() == 0));
        chk("full", int'(bus.full), int'(q.size() == 16));
        chk("overrun", int'(bus.overrun), int'(m_ov));
        chk("ser_nrts", int'(bus.ser_nrts), int'(m_nrts));
        if (q.size() > 0) chk("head", int'(bus.rd_data), int'(q[0]));
        @(negedge clock);
    endtask

    task automatic do_reset(input logic att, input logic r);
        rst              = 1'b1;
        bus.rx_attention = att;
        bus.rx_data      = 8'hEE;
        bus.rd           = r;
        bus.clr_overrun  = 1'b0;
        @(posedge clock);
        #1;
        q.delete();
        m_ov   = 1'b0;
        m_nrts = 1'b1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_ser_nrts", int'(bus.ser_nrts), 1);
        @(negedge clock);
        rst              = 1'b0;
        bus.rx_attention = 1'b0;
        bus.rd           = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        bus.rx_attention = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rd           = 1'b0;
        bus.clr_overrun  = 1'b0;
        m_ov             = 1'b0;
        m_nrts           = 1'b1;
        last_pop         = 8'h00;

        vecs[0] = '{1'b1, 8'h41, 1'b0, 1, 1'b0, 8'h41};
        vecs[1] = '{1'b1, 8'h42, 1'b0, 2, 1'b0, 8'h41};
        vecs[2] = '{1'b1, 8'h43, 1'b0, 3, 1'b0, 8'h41};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 8'h42};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h43};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00};
        vecs[7] = '{1'b1, 8'h77, 1'b1, 1, 1'b0, 8'h77};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00};

        @(negedge clock);
        do_reset(1'b0, 1'b0);
        idle();
        chk("nrts_after_release", int'(bus.ser_nrts), 0);

        // Basic push/pop, rd while empty, and push+rd into an empty queue.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].att, vecs[i].data, vecs[i].rd, 1'b0);
            chk("vec_count", int'(bus.count), vecs[i].exp_count);
            chk("vec_empty", int'(bus.empty), int'(vecs[i].exp_empty));
            if (!vecs[i].exp_empty) chk("vec_head", int'(bus.rd_data), int'(vecs[i].exp_head));
        end

        // Fill, then drop one byte into the full queue.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("drop_full", int'(bus.full), 1);
        chk("drop_overrun", int'(bus.overrun), 1);
        chk("drop_count", int'(bus.count), 16);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_last", int'(last_pop), 8'h0F);
        chk("drain_empty", int'(bus.empty), 1);

        // Clear overrun, then push and pop together on a full queue.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_overrun", int'(bus.overrun), 0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("full_pushpop_count", int'(bus.count), 16);
        chk("full_pushpop_ovr", int'(bus.overrun), 0);
        chk("full_pushpop_pop", int'(last_pop), 8'h80);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pushpop_16th", int'(last_pop), 8'h55);

        // Set and clear in the same cycle: set wins.
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("set_wins", int'(bus.overrun), 1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

        // RTS hysteresis.
        for (int i = 0; i < 12; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        idle();
        chk("nrts_hi", int'(bus.ser_nrts), 1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("nrts_at5", int'(bus.ser_nrts), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("nrts_at4", int'(bus.ser_nrts), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming across the pointer wrap, then reset mid-stream.
        for (int i = 0; i < 20; i++) step(1'b1, 8'hC0 + 8'(i), 1'(i % 2), 1'b0);
        do_reset(1'b1, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
        chk("post_rst_head", int'(bus.rd_data), 8'h31);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_last", int'(last_pop), 8'h33);
        chk("post_rst_empty", int'(bus.empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
